// File: rtl/display_pkg.sv
// Shared types and sizing helpers for the HUB75 scan controller.
package display_pkg;

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, SHIFT, BLANK, LATCH, DISPLAY, SWAP
    } scan_state_e;

    localparam int PANEL_COLS      = 64;
    localparam int PANEL_ROW_PAIRS = 32;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Frame-buffer read port, frame swap handshake and HUB75 panel pins in one bundle.
interface display_scan_if #(
    parameter int COLS      = display_pkg::PANEL_COLS,
    parameter int ROW_PAIRS = display_pkg::PANEL_ROW_PAIRS
);
    localparam int ADDR_W = display_pkg::cnt_width(ROW_PAIRS);
    localparam int SEL_W  = ADDR_W + 1;

    logic              frame_ready;
    logic              frame_ack;
    logic              get_buffer;
    logic              r_enable;
    logic [SEL_W-1:0]  row_0_sel;
    logic [SEL_W-1:0]  row_1_sel;
    logic [COLS-1:0]   row_0;
    logic [COLS-1:0]   row_1;
    logic              r1;
    logic              r2;
    logic [ADDR_W-1:0] addr;
    logic              sclk;
    logic              lat;
    logic              oe_n;

    modport master (
        input  frame_ready, row_0, row_1,
        output frame_ack, get_buffer, r_enable, row_0_sel, row_1_sel,
               r1, r2, addr, sclk, lat, oe_n
    );

    modport slave (
        output frame_ready, row_0, row_1,
        input  frame_ack, get_buffer, r_enable, row_0_sel, row_1_sel,
               r1, r2, addr, sclk, lat, oe_n
    );

endinterface

// File: rtl/display_scan_controller_hub75_shifter.sv
// Serialises two loaded rows MSB-first onto r1/r2 with a divided sclk; pulses done
// combinationally in the last high-phase cycle of column 0.
module hub75_shifter
    import display_pkg::*;
#(
    parameter int COLS    = PANEL_COLS,
    parameter int CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [COLS-1:0] row_0_in,
    input  logic [COLS-1:0] row_1_in,
    output logic            r1,
    output logic            r2,
    output logic            sclk,
    output logic            done
);
    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam int COL_W = cnt_width(COLS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [COLS-1:0]  sh0_q, sh0_d, sh1_q, sh1_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             active_q, active_d;
    logic             sclk_q, sclk_d;
    logic             r1_q, r1_d, r2_q, r2_d;
    logic             phase_end;

    assign phase_end = active_q && (div_q == DIV_LAST);
    assign done      = phase_end && sclk_q && (col_q == '0);

    always_comb begin
        sh0_d    = sh0_q;
        sh1_d    = sh1_q;
        col_d    = col_q;
        div_d    = div_q;
        active_d = active_q;
        sclk_d   = sclk_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        if (load) begin
            // The MSB goes straight to the pins; the shift regs hold the remaining columns.
            sh0_d    = row_0_in << 1;
            sh1_d    = row_1_in << 1;
            r1_d     = row_0_in[COLS-1];
            r2_d     = row_1_in[COLS-1];
            col_d    = COL_W'(COLS - 1);
            div_d    = '0;
            sclk_d   = 1'b0;
            active_d = 1'b1;
        end else if (active_q) begin
            div_d = phase_end ? '0 : div_q + 1'b1;
            if (phase_end) begin
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    if (col_q == '0) begin
                        active_d = 1'b0;
                    end else begin
                        col_d = col_q - 1'b1;
                        r1_d  = sh0_q[COLS-1];
                        r2_d  = sh1_q[COLS-1];
                        sh0_d = sh0_q << 1;
                        sh1_d = sh1_q << 1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh0_q    <= '0;
            sh1_q    <= '0;
            col_q    <= '0;
            div_q    <= '0;
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            r1_q     <= 1'b0;
            r2_q     <= 1'b0;
        end else begin
            sh0_q    <= sh0_d;
            sh1_q    <= sh1_d;
            col_q    <= col_d;
            div_q    <= div_d;
            active_q <= active_d;
            sclk_q   <= sclk_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
        end
    end

    assign r1   = r1_q;
    assign r2   = r2_q;
    assign sclk = sclk_q;

endmodule

// File: rtl/display_scan_controller.sv
// Scan sequencer: fetches a row pair, shifts it out, blanks, latches, displays,
// and swaps frames at the frame boundary when the write side has one ready.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int COLS      = PANEL_COLS,
    parameter int ROW_PAIRS = PANEL_ROW_PAIRS,
    parameter int CLK_DIV   = 2,
    parameter int BLANK_CYC = 2,
    parameter int OE_HOLD   = 256
) (
    input  logic          clk,
    input  logic          reset,
    display_scan_if.master bus
);
    localparam int P_W     = cnt_width(ROW_PAIRS);
    localparam int SEL_W   = P_W + 1;
    localparam int CNT_MAX = (BLANK_CYC > OE_HOLD) ? BLANK_CYC : OE_HOLD;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [P_W-1:0] P_LAST = P_W'(ROW_PAIRS - 1);

    scan_state_e      state_q;
    logic [P_W-1:0]   p_q;
    logic [P_W-1:0]   p_inc;
    logic [CNT_W-1:0] cnt_q;
    logic             r_enable_q, get_buffer_q, frame_ack_q, lat_q, oe_n_q;
    logic [SEL_W-1:0] row_0_sel_q, row_1_sel_q;
    logic [P_W-1:0]   addr_q;
    logic             shift_done;

    assign p_inc = p_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            p_q          <= '0;
            cnt_q        <= '0;
            r_enable_q   <= 1'b0;
            get_buffer_q <= 1'b0;
            frame_ack_q  <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            row_0_sel_q  <= '0;
            row_1_sel_q  <= '0;
            addr_q       <= '0;
        end else begin
            r_enable_q   <= 1'b0;
            get_buffer_q <= 1'b0;
            frame_ack_q  <= 1'b0;
            lat_q        <= 1'b0;
            unique case (state_q)
                IDLE, SWAP: begin
                    state_q     <= FETCH;
                    r_enable_q  <= 1'b1;
                    row_0_sel_q <= SEL_W'(p_q);
                    row_1_sel_q <= SEL_W'(p_q) + SEL_W'(ROW_PAIRS);
                end
                FETCH: state_q <= WAIT;
                WAIT:  state_q <= SHIFT;
                SHIFT: begin
                    if (shift_done) begin
                        if (BLANK_CYC > 0) begin
                            state_q <= BLANK;
                            cnt_q   <= CNT_W'(BLANK_CYC - 1);
                        end else begin
                            state_q <= LATCH;
                            lat_q   <= 1'b1;
                            addr_q  <= p_q;
                        end
                    end
                end
                BLANK: begin
                    if (cnt_q == '0) begin
                        state_q <= LATCH;
                        lat_q   <= 1'b1;
                        addr_q  <= p_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                LATCH: begin
                    state_q <= DISPLAY;
                    oe_n_q  <= 1'b0;
                    cnt_q   <= CNT_W'(OE_HOLD - 1);
                end
                DISPLAY: begin
                    if (cnt_q == '0) begin
                        oe_n_q <= 1'b1;
                        if (p_q == P_LAST) begin
                            // frame_ready is looked at once, as SWAP is entered, so the pulse lands in SWAP.
                            p_q          <= '0;
                            state_q      <= SWAP;
                            get_buffer_q <= bus.frame_ready;
                            frame_ack_q  <= bus.frame_ready;
                        end else begin
                            p_q         <= p_inc;
                            state_q     <= FETCH;
                            r_enable_q  <= 1'b1;
                            row_0_sel_q <= SEL_W'(p_inc);
                            row_1_sel_q <= SEL_W'(p_inc) + SEL_W'(ROW_PAIRS);
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Rows are captured at the end of WAIT, the cycle the buffer presents them.
    hub75_shifter #(
        .COLS    (COLS),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == WAIT),
        .row_0_in (bus.row_0),
        .row_1_in (bus.row_1),
        .r1       (bus.r1),
        .r2       (bus.r2),
        .sclk     (bus.sclk),
        .done     (shift_done)
    );

    assign bus.r_enable   = r_enable_q;
    assign bus.get_buffer = get_buffer_q;
    assign bus.frame_ack  = frame_ack_q;
    assign bus.row_0_sel  = row_0_sel_q;
    assign bus.row_1_sel  = row_1_sel_q;
    assign bus.lat        = lat_q;
    assign bus.oe_n       = oe_n_q;
    assign bus.addr       = addr_q;

endmodule
